ttt_game_ctrl: RTL and testbench

- Tic-tac-toe game controller: accepts player moves, keeps the board, alternates turns, detects win/tie, keeps a win score.
- Sits directly upstream of the VGA bit-change stage and drives that stage's per-cell filled flags, current player P, won, tie, game and score.
- Holds P stable for one full video frame after each move, so the display latches the correct colour for the newly filled cell before the turn changes.

---
 rtl/ttt_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe controller: board, turns, win/tie detect, saturating score.
// Optional TTT_ALT_START_EN: starting player alternates on every new_game.
module ttt_game_ctrl #(
  parameter int FRAME_CYCLES = 420000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move,
  input  logic [8:0]  cell_sel,
  output logic [8:0]  F,
  output logic [8:0]  owner,
  output logic        P,
  output logic        game,
  output logic        won,
  output logic        tie,
  output logic        winner,
  output logic        illegal,
  output logic [15:0] score
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
  localparam logic [2:0] ST_TIE   = 3'd5;

  localparam logic [19:0] HOLD_LOAD = 20'(FRAME_CYCLES - 1);

  logic [2:0]  r_state;
  logic [19:0] r_cnt;
  logic [8:0]  r_f;
  logic [8:0]  r_owner;
  logic        r_p;
  logic        r_won;
  logic        r_tie;
  logic        r_winner;
  logic        r_illegal;
  logic [7:0]  r_score0;
  logic [7:0]  r_score1;

  logic        w_onehot;
  logic        w_legal;
  logic [8:0]  w_mine;
  logic        w_win;
  logic        w_start;

  function automatic logic line_win(input logic [8:0] m);
    return ((m & 9'h007) == 9'h007) || ((m & 9'h038) == 9'h038) ||
           ((m & 9'h1C0) == 9'h1C0) || ((m & 9'h049) == 9'h049) ||
           ((m & 9'h092) == 9'h092) || ((m & 9'h124) == 9'h124) ||
           ((m & 9'h111) == 9'h111) || ((m & 9'h054) == 9'h054);
  endfunction

  assign w_onehot = (cell_sel != 9'd0) && ((cell_sel & (cell_sel - 9'd1)) == 9'd0);
  assign w_legal  = w_onehot && ((cell_sel & r_f) == 9'd0);
  // owner is 0 on empty cells, so P0's cells are the filled ones with owner 0
  assign w_mine   = r_p ? r_owner : (r_f & ~r_owner);
  assign w_win    = line_win(w_mine);

`ifdef TTT_ALT_START_EN
  logic r_alt;
  assign w_start = r_alt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alt <= 1'b0;
    end else if (new_game) begin
      r_alt <= ~r_alt;
    end
  end
`else
  assign w_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 20'd0;
      r_f       <= 9'd0;
      r_owner   <= 9'd0;
      r_p       <= 1'b0;
      r_won     <= 1'b0;
      r_tie     <= 1'b0;
      r_winner  <= 1'b0;
      r_illegal <= 1'b0;
      r_score0  <= 8'd0;
      r_score1  <= 8'd0;
    end else begin
      r_illegal <= 1'b0;
      if (new_game) begin
        r_f     <= 9'd0;
        r_owner <= 9'd0;
        r_won   <= 1'b0;
        r_tie   <= 1'b0;
        r_p     <= w_start;
        r_cnt   <= 20'd0;
        r_state <= ST_PLAY;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (move) begin
              if (w_legal) begin
                r_f     <= r_f | cell_sel;
                r_owner <= r_owner | (r_p ? cell_sel : 9'd0);
                r_cnt   <= HOLD_LOAD;
                r_state <= ST_HOLD;
              end else begin
                r_illegal <= 1'b1;
              end
            end
          end
          // P stays put for a full frame so the display paints the new cell in the mover's colour
          ST_HOLD: begin
            if (r_cnt == 20'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_cnt <= r_cnt - 20'd1;
            end
          end
          ST_CHECK: begin
            if (w_win) begin
              r_won    <= 1'b1;
              r_winner <= r_p;
              r_state  <= ST_WIN;
              if (r_p == 1'b0) begin
                if (r_score0 != 8'hFF) r_score0 <= r_score0 + 8'd1;
              end else begin
                if (r_score1 != 8'hFF) r_score1 <= r_score1 + 8'd1;
              end
            end else if (r_f == 9'h1FF) begin
              r_tie   <= 1'b1;
              r_state <= ST_TIE;
            end else begin
              r_p     <= ~r_p;
              r_state <= ST_PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign F       = r_f;
  assign owner   = r_owner;
  assign P       = r_p;
  assign game    = (r_state == ST_PLAY) || (r_state == ST_HOLD) || (r_state == ST_CHECK);
  assign won     = r_won;
  assign tie     = r_tie;
  assign winner  = r_winner;
  assign illegal = r_illegal;
  assign score   = {r_score0, r_score1};

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - randomized bench for ttt_game_ctrl against a board-array reference model.
module tb_ttt_game_ctrl;

  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        move;
  logic [8:0]  cell_sel;
  logic [8:0]  F;
  logic [8:0]  owner;
  logic        P;
  logic        game;
  logic        won;
  logic        tie;
  logic        winner;
  logic        illegal;
  logic [15:0] score;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 empty, 1 green, 2 red
  int mb[9];
  int mp, mphase, mwon, mtie, mwinner, ms0, ms1, malt;

  ttt_game_ctrl #(.FRAME_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .move(move), .cell_sel(cell_sel),
    .F(F), .owner(owner), .P(P), .game(game), .won(won), .tie(tie),
    .winner(winner), .illegal(illegal), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_f();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (mb[i] != 0);
    return v;
  endfunction

  function automatic logic [8:0] exp_owner();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (mb[i] == 2);
    return v;
  endfunction

  function automatic bit has_line(input int who);
    int L[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++)
      if (mb[L[l][0]] == who && mb[L[l][1]] == who && mb[L[l][2]] == who) return 1;
    return 0;
  endfunction

  function automatic bit board_full();
    for (int i = 0; i < 9; i++) if (mb[i] == 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mp = 0; mphase = 0; mwon = 0; mtie = 0; mwinner = 0; ms0 = 0; ms1 = 0; malt = 0;
  endtask

  task automatic model_new_game();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mwon = 0; mtie = 0; mphase = 1;
`ifdef TTT_ALT_START_EN
    mp = malt;
    malt = 1 - malt;
`else
    mp = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".F"}, 32'(F), 32'(exp_f()));
    chk({tag, ".owner"}, 32'(owner), 32'(exp_owner()));
    chk({tag, ".P"}, 32'(P), 32'(mp));
    chk({tag, ".game"}, 32'(game), 32'(mphase));
    chk({tag, ".won"}, 32'(won), 32'(mwon));
    chk({tag, ".tie"}, 32'(tie), 32'(mtie));
    chk({tag, ".score"}, 32'(score), 32'(ms0 * 256 + ms1));
    if (mwon != 0) chk({tag, ".winner"}, 32'(winner), 32'(mwinner));
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_new_game();
    check_all("newgame");
    chk("newgame.illegal", 32'(illegal), 32'd0);
  endtask

  task automatic ng_with_move();
    @(negedge clk); new_game = 1'b1; move = 1'b1; cell_sel = 9'd1 << $urandom_range(0, 8);
    @(negedge clk); new_game = 1'b0; move = 1'b0; cell_sel = '0;
    model_new_game();
    check_all("ngmove");
    chk("ngmove.illegal", 32'(illegal), 32'd0);
  endtask

  task automatic do_move(input logic [8:0] cs);
    int idx = -1, ones = 0;
    bit legal;
    for (int i = 0; i < 9; i++) if (cs[i]) begin ones++; idx = i; end
    legal = (mphase == 1) && (ones == 1) && (mb[idx] == 0);
    @(negedge clk); move = 1'b1; cell_sel = cs;
    @(negedge clk); move = 1'b0; cell_sel = '0;
    if (legal) begin
      mb[idx] = mp + 1;
      check_all("accept");
      chk("accept.illegal", 32'(illegal), 32'd0);
      move = 1'b1; cell_sel = 9'($urandom_range(0, 511));
      @(negedge clk); move = 1'b0; cell_sel = '0;
      chk("hold.illegal", 32'(illegal), 32'd0);
      chk("hold.F", 32'(F), 32'(exp_f()));
      repeat (FC - 1) @(negedge clk);
      check_all("check");
      @(negedge clk);
      if (has_line(mp + 1)) begin
        mwon = 1; mwinner = mp; mphase = 0;
        if (mp == 0) ms0 = (ms0 < 255) ? ms0 + 1 : 255;
        else         ms1 = (ms1 < 255) ? ms1 + 1 : 255;
      end else if (board_full()) begin
        mtie = 1; mphase = 0;
      end else begin
        mp = 1 - mp;
      end
      check_all("result");
    end else begin
      chk("reject.illegal", 32'(illegal), 32'(mphase));
      check_all("reject");
      @(negedge clk);
      chk("reject.pulse", 32'(illegal), 32'd0);
    end
  endtask

  task automatic play(input int cells[$]);
    foreach (cells[k]) do_move(9'd1 << cells[k]);
  endtask

  initial begin
    reset = 1'b0; new_game = 1'b0; move = 1'b0; cell_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.winner", 32'(winner), 32'd0);
    reset = 1'b1;
    do_move(9'h001);

    do_new_game();
    do_move(9'h001);

    do_new_game();
    play('{0, 1, 4, 2, 8});
    do_move(9'h008);
    do_move(9'h000);

    do_new_game();
    do_move(9'h001);
    do_move(9'h001);
    do_move(9'h000);
    do_move(9'h003);

    do_new_game();
    play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
    do_new_game();

    do_move(9'h010);
    do_move(9'h020);
    ng_with_move();

    // asynchronous reset in the middle of HOLD
    @(negedge clk); move = 1'b1; cell_sel = 9'h001;
    @(negedge clk); move = 1'b0; cell_sel = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("asyncrst");
    chk("asyncrst.illegal", 32'(illegal), 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int g = 0; g < 258; g++) begin
      do_new_game();
      if (mp == 1) play('{0, 3, 1, 4, 2});
      else         play('{3, 0, 4, 1, 8, 2});
    end
    chk("sat.p1", 32'(score[7:0]), 32'hFF);

    for (int g = 0; g < 30; g++) begin
      do_new_game();
      for (int k = 0; k < 30; k++) begin
        int r = $urandom_range(0, 99);
        if (r < 3)       do_new_game();
        else if (r < 6)  ng_with_move();
        else if (r < 20) do_move(9'($urandom_range(0, 511)));
        else             do_move(9'd1 << $urandom_range(0, 8));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
